// File: rtl/inverter_share_pkg.sv
// ---------------------------------------------------------------------------
// inverter_share_pkg
//   Shared definitions for the inverter-sharing arbiter slice:
//     state_t  - output stage state (EMPTY / FULL)
//     REQ_N    - default requester count
//     DATA_W   - default operand width
//     id_w()   - width of a requester index for a given requester count
//     ID_W     - index width for the default requester count
// ---------------------------------------------------------------------------
package inverter_share_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int REQ_N  = 4;
    localparam int DATA_W = 8;

    // A single requester would give clog2 = 0; keep at least one bit so the
    // index ports never collapse to zero width.
    function automatic int id_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int ID_W = id_w(REQ_N);

endpackage

// File: rtl/inverter1bit.sv
// ---------------------------------------------------------------------------
// inverter1bit
//   The shared bitwise inverter datapath. Purely combinational.
//   Ports:
//     a : operand in
//     y : bitwise complement of a
// ---------------------------------------------------------------------------
module inverter1bit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    assign y = ~a;

endmodule

// File: rtl/rr_priority_picker.sv
// ---------------------------------------------------------------------------
// rr_priority_picker
//   Combinational round-robin search: the winner is the first asserted
//   request found scanning ptr, ptr+1, ... modulo N_REQ.
//   Ports:
//     req     : request vector
//     ptr     : index with highest priority this cycle
//     grant   : one-hot winner (all zero when no request)
//     winner  : binary index of the winner (0 when no request)
//     any_req : at least one request is asserted
// ---------------------------------------------------------------------------
module rr_priority_picker
    import inverter_share_pkg::*;
#(
    parameter int N_REQ = REQ_N,
    parameter int IDX_W = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    always_comb begin
        int idx;
        idx     = 0;
        grant   = '0;
        winner  = '0;
        any_req = |req;
        // Scan from the farthest position back toward ptr so the nearest
        // asserted request (in rotation order) is the last one written.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (req[idx]) begin
                winner = IDX_W'(idx);
            end
        end
        if (any_req) begin
            grant[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/inverter_share_arbiter.sv
// ---------------------------------------------------------------------------
// inverter_share_arbiter
//   Shares one inverter datapath among N_REQ requesters. A round-robin
//   picker selects one valid requester, its operand is inverted and loaded
//   into a single-entry output register tagged with the requester index.
//   The output register may drain and reload in the same cycle, giving one
//   result per cycle when the consumer keeps out_ready high.
//   Ports:
//     clk, reset  : clock, synchronous active-high reset
//     req_valid   : per-requester operand pending
//     req_data    : operand i at [i*WIDTH +: WIDTH]
//     req_ready   : one-hot acceptance of the winning requester
//     out_valid   : output register holds a result
//     out_data    : inverted operand of the captured requester
//     out_id      : index of the captured requester
//     out_ready   : consumer accepts the result this cycle
//     busy        : same as out_valid
//     xfer_count  : completed output transfers, wraps
// ---------------------------------------------------------------------------
module inverter_share_arbiter
    import inverter_share_pkg::*;
#(
    parameter int N_REQ = REQ_N,
    parameter int WIDTH = DATA_W,
    parameter int CNT_W = 16,
    localparam int IDW  = id_w(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [IDW-1:0]         out_id,
    input  logic                   out_ready,
    output logic                   busy,
    output logic [CNT_W-1:0]       xfer_count
);

    state_t             state;
    logic [IDW-1:0]     rr_ptr;
    logic               init_q;

    logic [N_REQ-1:0]   pick_grant;
    logic [IDW-1:0]     winner;
    logic               any_req;
    logic               accept_ok;
    logic               do_grant;
    logic               drain;
    logic [WIDTH-1:0]   win_data;
    logic [WIDTH-1:0]   inv_data;

    rr_priority_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDW)
    ) u_picker (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .grant   (pick_grant),
        .winner  (winner),
        .any_req (any_req)
    );

    assign win_data = req_data[int'(winner)*WIDTH +: WIDTH];

    inverter1bit #(
        .WIDTH (WIDTH)
    ) u_inverter (
        .a (win_data),
        .y (inv_data)
    );

    // Grants are held off while reset is asserted and for the first cycle
    // after each reset edge, so no requester sees a handshake that the
    // reset would then silently discard.
    assign drain     = (state == FULL) && out_ready;
    assign accept_ok = !reset && !init_q && ((state == EMPTY) || out_ready);
    assign do_grant  = accept_ok && any_req;
    assign req_ready = do_grant ? pick_grant : '0;

    assign out_valid = (state == FULL);
    assign busy      = out_valid;

    // Output stage: capture on grant, otherwise drain to EMPTY on transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            out_data   <= '0;
            out_id     <= '0;
            rr_ptr     <= '0;
            xfer_count <= '0;
            init_q     <= 1'b1;
        end else begin
            init_q <= 1'b0;
            if (drain) begin
                xfer_count <= xfer_count + CNT_W'(1);
            end
            if (do_grant) begin
                state    <= FULL;
                out_data <= inv_data;
                out_id   <= winner;
                rr_ptr   <= (winner == IDW'(N_REQ - 1)) ? '0 : winner + IDW'(1);
            end else if (drain) begin
                state <= EMPTY;
            end
        end
    end

    // Grants only go to requesters that are asking, at most one at a time.
    a_ready_subset: assert property (@(posedge clk) disable iff (reset)
        (req_ready & ~req_valid) == '0);
    a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(req_ready));
    // A stalled result stays put until the consumer takes it.
    a_stall_stable: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_id)));

endmodule

// File: tb/tb_inverter_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_inverter_share_arbiter
//   Directed scenarios followed by randomized traffic, compared every cycle
//   against a transaction-level reference of the arbiter.
// ---------------------------------------------------------------------------
module tb_inverter_share_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [1:0]       out_id;
    logic             out_ready;
    logic             busy;
    logic [CW-1:0]    xfer_count;

    inverter_share_arbiter #(
        .N_REQ (N),
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_ready  (out_ready),
        .busy       (busy),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: output slot contents, rotation pointer, transfer count.
    bit          m_full  = 1'b0;
    logic [W-1:0] m_data = '0;
    int          m_id    = 0;
    int          m_ptr   = 0;
    int          m_cnt   = 0;
    bit          m_block = 1'b1;
    int          m_win   = -1;

    function automatic int model_pick();
        if (reset || m_block || (m_full && !out_ready)) return -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic settle();
        #1;
        m_win = model_pick();
        check("req_ready", 32'(req_ready), (m_win < 0) ? 32'd0 : (32'd1 << m_win));
        check("ready_vs_valid", 32'(req_ready & ~req_valid), 32'd0);
        check("out_valid", 32'(out_valid), 32'(m_full));
        check("busy", 32'(busy), 32'(m_full));
        check("out_data", 32'(out_data), 32'(m_data));
        check("out_id", 32'(out_id), 32'(m_id));
        check("xfer_count", 32'(xfer_count), 32'(m_cnt));
    endtask

    task automatic advance();
        bit drain;
        drain = m_full && out_ready;
        if (reset) begin
            m_full = 0; m_data = '0; m_id = 0; m_ptr = 0; m_cnt = 0; m_block = 1;
        end else begin
            m_block = 0;
            if (drain) m_cnt = (m_cnt + 1) % (1 << CW);
            if (m_win >= 0) begin
                m_full = 1;
                m_data = ~req_data[m_win*W +: W];
                m_id   = m_win;
                m_ptr  = (m_win + 1) % N;
            end else if (drain) begin
                m_full = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1; req_valid = '0; out_ready = 0;
        settle();
        advance();
        reset = 0;
    endtask

    task automatic idle_cycle();
        req_valid = '0;
        settle();
        advance();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    bit           pend  [N];
    logic [W-1:0] pdata [N];
    logic [N-1:0] seen;

    initial begin
        logic [W-1:0] rr_exp [4];
        rr_exp[0] = 8'hFF; rr_exp[1] = 8'h00; rr_exp[2] = 8'h52; rr_exp[3] = 8'h29;

        reset = 1; req_valid = '0; req_data = '0; out_ready = 0;
        @(posedge clk);
        @(negedge clk);

        // Reset held two cycles, then idle.
        do_reset();
        do_reset();
        settle();
        check("idle_ready", 32'(req_ready), 32'd0);
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_count", 32'(xfer_count), 32'd0);
        advance();

        // Single request.
        req_valid = 4'b0001; req_data[7:0] = 8'b10101101; out_ready = 1;
        settle();
        check("single_ready", 32'(req_ready), 32'b0001);
        advance();
        req_valid = '0;
        settle();
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_data", 32'(out_data), 32'b01010010);
        check("single_id", 32'(out_id), 32'd0);
        advance();
        settle();
        check("single_count", 32'(xfer_count), 32'd1);
        advance();

        // Round-robin with all requesters continuously valid.
        do_reset();
        idle_cycle();
        req_data = {8'hD6, 8'hAD, 8'hFF, 8'h00};
        req_valid = 4'b1111; out_ready = 1;
        for (int c = 0; c < 6; c++) begin
            settle();
            if (c >= 1) begin
                check("rr_id", 32'(out_id), 32'((c - 1) % 4));
                check("rr_data", 32'(out_data), 32'(rr_exp[(c - 1) % 4]));
            end
            advance();
        end

        // Stall with another requester waiting.
        do_reset();
        idle_cycle();
        req_valid = 4'b0100; req_data[23:16] = 8'hD6; out_ready = 0;
        settle();
        check("stall_grant", 32'(req_ready), 32'b0100);
        advance();
        req_valid = 4'b1000; req_data[31:24] = 8'h3C;
        for (int c = 0; c < 3; c++) begin
            settle();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'h29);
            check("stall_id", 32'(out_id), 32'd2);
            check("stall_ready", 32'(req_ready), 32'd0);
            advance();
        end
        out_ready = 1;
        settle();
        check("stall_release", 32'(req_ready), 32'b1000);
        advance();
        req_valid = '0;
        settle();
        check("stall_next_id", 32'(out_id), 32'd3);
        check("stall_next_data", 32'(out_data), 32'hC3);
        check("stall_count", 32'(xfer_count), 32'd1);
        advance();

        // Back-to-back drain and capture.
        do_reset();
        idle_cycle();
        req_valid = 4'b1010; req_data[15:8] = 8'h11; req_data[31:24] = 8'h33; out_ready = 1;
        settle();
        check("b2b_first", 32'(req_ready), 32'b0010);
        advance();
        req_valid = 4'b1000;
        settle();
        check("b2b_id1", 32'(out_id), 32'd1);
        check("b2b_second", 32'(req_ready), 32'b1000);
        advance();
        req_valid = '0;
        settle();
        check("b2b_valid", 32'(out_valid), 32'd1);
        check("b2b_id3", 32'(out_id), 32'd3);
        check("b2b_data", 32'(out_data), 32'hCC);
        advance();

        // Reset while FULL and stalled.
        req_valid = 4'b0001; req_data[7:0] = 8'h5A; out_ready = 0;
        settle();
        advance();
        req_valid = '0;
        settle();
        advance();
        reset = 1; out_ready = 1;
        settle();
        advance();
        reset = 0; out_ready = 0; req_valid = 4'b1111;
        settle();
        check("mid_valid", 32'(out_valid), 32'd0);
        check("mid_id", 32'(out_id), 32'd0);
        check("mid_count", 32'(xfer_count), 32'd0);
        advance();
        settle();
        check("mid_first_win", 32'(req_ready), 32'b0001);
        advance();

        // Randomized traffic; each requester holds its operand until accepted.
        for (int i = 0; i < N; i++) pend[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 199) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]  = 1;
                    pdata[i] = W'($urandom);
                end
                req_valid[i]        = pend[i];
                req_data[i*W +: W]  = pdata[i];
            end
            settle();
            seen = req_ready;
            advance();
            for (int i = 0; i < N; i++) if (seen[i]) pend[i] = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inverter_share_arbiter.md
Name: inverter_share_arbiter

Overview:
Shares one 8-bit inverter datapath (existing inverter1bit) among N_REQ requesters using round-robin arbitration with valid/ready handshakes. The granted operand passes through the inverter. The result is registered in a single-entry output stage, tagged with the requester ID. The block sits between the requester ports and the shared inverter and sequences all access to it.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 8, operand/result width in bits
CNT_W, 16, width of completed-transfer counter

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  N_REQ  requester i has an operand pending
req_data  in  N_REQ*WIDTH  operand of requester i at bits [i*WIDTH +: WIDTH]
req_ready  out  N_REQ  one-hot grant; requester i's operand is accepted this cycle
out_valid  out  1  output register holds a result
out_data  out  WIDTH  inverted operand (~req_data of granted requester)
out_id  out  clog2(N_REQ)  index of requester that produced out_data
out_ready  in  1  consumer accepts the result this cycle
busy  out  1  equals out_valid
xfer_count  out  CNT_W  number of completed output transfers (out_valid && out_ready), wraps modulo 2^CNT_W

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset, sampled on a clk edge, forces the following values:
  - state=EMPTY, out_valid=0, out_data=0, out_id=0, xfer_count=0.
  - Round-robin pointer rr_ptr=0, so requester 0 has highest priority first.
  - req_ready=0 in the cycle after reset.
- Reset mid-operation discards any held result without a transfer, and xfer_count is not incremented.
- FSM states:
  - EMPTY: no result held.
  - FULL: result held, out_valid=1.
- accept_ok = (state==EMPTY) || (state==FULL && out_ready).
- Grant (combinational):
  - Applies when accept_ok and any req_valid.
  - Winner is the first i with req_valid[i], searching i = rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - req_ready is one-hot at the winner, otherwise all zero.
  - req_ready must never assert for a requester whose req_valid=0.
- Capture on a grant, at the clock edge:
  - out_data <= ~req_data[winner]; out_id <= winner; state <= FULL.
  - rr_ptr <= (winner+1) mod N_REQ.
  - Latency is exactly 1 cycle from handshake to out_valid.
- FULL with out_ready=1 and no req_valid: state <= EMPTY; out_data/out_id hold their last values.
- FULL with out_ready=0 (stall):
  - All req_ready=0.
  - out_valid, out_data and out_id are stable until accepted.
  - rr_ptr is unchanged.
- Simultaneous drain and capture: in FULL with out_ready=1 and a grant, the old result transfers and the new one loads in the same cycle. state stays FULL, and throughput is 1 result/cycle.
- xfer_count increments on every cycle with out_valid && out_ready; it wraps from 2^CNT_W-1 to 0.
- rr_ptr advances only on a grant, never on idle cycles.
- Requester rule: once req_valid is asserted, req_valid/req_data must hold until req_ready. The bench checks this; the RTL does not depend on it.
- Fairness: with all requesters continuously valid and out_ready=1, grants rotate 0,1,...,N_REQ-1,0,...
- No combinational path from out_ready to out_valid/out_data. The path out_ready -> req_ready is permitted.

Decomposition:
- Package inverter_share_pkg contains:
  - state typedef (EMPTY, FULL);
  - default constants REQ_N=4, DATA_W=8;
  - ID width function/localparam clog2(N_REQ).
- Sub-module rr_priority_picker (inputs: request vector, rr_ptr; outputs: one-hot grant, winner index, any_req).
- The shared inverter1bit is instantiated once on the muxed winner operand.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, all req_valid=0 -> out_valid=0, req_ready=0000, xfer_count=0.
- Single request:
  - Stimulus: req_valid=0001, data0=8'b10101101, out_ready=1.
  - Response: req_ready=0001 in cycle 0; in cycle 1, out_valid=1, out_data=8'b01010010, out_id=0; xfer_count=1 after the transfer.
- Round-robin:
  - Stimulus: all four valid with data0..3 = 00,FF,AD,D6 (hex); out_ready=1 and held high.
  - Response: out_id sequence 0,1,2,3,0; out_data sequence FF,00,52,29.
- Stall:
  - Stimulus: req 2 valid with 8'hD6; out_ready=0 for 3 cycles.
  - Response: out_valid=1, out_data=8'h29, out_id=2 stable; req_ready=0000 during the stall.
  - Then out_ready=1: transfer occurs, and the next grant goes to requester 3 if valid.
- Back-to-back drain and capture:
  - Stimulus: requesters 1 and 3 valid; out_ready=1.
  - Response: results on consecutive cycles (ids 1,3) with no bubble; state stays FULL.
- Reset mid-operation:
  - Stimulus: assert reset while FULL and stalled.
  - Response: next cycle out_valid=0, out_id=0, rr_ptr=0; xfer_count is not incremented; requester 0 wins the first post-reset grant.
